// File: rtl/fb_dmem_ctrl_if.sv
// Data-bus bundle between the MEM-stage controller (master) and memory (slave).
interface fb_dmem_ctrl_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        dbus_err;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        input  dbus_ack, dbus_rdata, dbus_err
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        output dbus_ack, dbus_rdata, dbus_err
    );
endinterface

// File: rtl/fb_dmem_ctrl.sv
// MEM-stage data-memory controller: launches one bus transaction per load/store,
// stalls the pipeline until it completes and delivers the extended load result.
module fb_dmem_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_mem_read,
    input  logic                 mem_mem_write,
    input  logic [2:0]           mem_funct3,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_store_data,
    output logic [31:0]          mem_memory_data,
    output logic                 memwb_we,
    output logic                 stall,
    output logic                 misalign,
    output logic                 mem_fault,
    fb_dmem_ctrl_if.master       dbus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic             load_q, load_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       lane_q, lane_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             fault_q, fault_d;

    logic             access, go, timeout;
    logic             illegal_f3, bad_align;
    logic [3:0]       store_strb;
    logic [31:0]      store_wdata;
    logic [7:0]       rd_byte [4];
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_ext;

    assign access  = mem_mem_read | mem_mem_write;
    assign go      = access & ~misalign;
    assign timeout = (cnt_q == CNT_LAST);

    // Split the read word into byte lanes for lane selection.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_byte[gi] = dbus.dbus_rdata[8*gi +: 8];
        end
    endgenerate

    // Access legality: illegal width codes and unaligned halves/words never reach the bus.
    always_comb begin
        illegal_f3 = (mem_funct3 == 3'b011) | (mem_funct3 == 3'b110) | (mem_funct3 == 3'b111);
        bad_align  = ((mem_funct3[1:0] == 2'b01) & mem_addr[0]) |
                     ((mem_funct3[1:0] == 2'b10) & (|mem_addr[1:0]));
        misalign   = access & (illegal_f3 | bad_align);
    end

    // Store lane strobes and replicated write data from width and address.
    always_comb begin
        case (mem_funct3[1:0])
            2'b00: begin
                store_strb  = 4'b0001 << mem_addr[1:0];
                store_wdata = {4{mem_store_data[7:0]}};
            end
            2'b01: begin
                store_strb  = 4'b0011 << {mem_addr[1], 1'b0};
                store_wdata = {2{mem_store_data[15:0]}};
            end
            default: begin
                store_strb  = 4'b1111;
                store_wdata = mem_store_data;
            end
        endcase
    end

    // Load alignment and sign/zero extension using the registered width and lane.
    always_comb begin
        ld_byte = rd_byte[lane_q];
        ld_half = lane_q[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dbus.dbus_rdata;
        endcase
    end

    // State register plus all datapath flops; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    // Next state: DONE always lasts one cycle so the stalled instruction leaves MEM first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_BUSY;
            S_BUSY:  if (dbus.dbus_ack || timeout) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next datapath values: latch the request on launch, capture result/fault on completion.
    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        load_d  = load_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        cnt_d   = '0;
        data_d  = data_q;
        fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    req_d   = 1'b1;
                    we_d    = mem_mem_write;
                    load_d  = mem_mem_read & ~mem_mem_write;
                    addr_d  = {mem_addr[31:2], 2'b00};
                    wstrb_d = mem_mem_write ? store_strb : 4'b0000;
                    wdata_d = store_wdata;
                    f3_d    = mem_funct3;
                    lane_d  = mem_addr[1:0];
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (dbus.dbus_ack) begin
                    req_d   = 1'b0;
                    fault_d = dbus.dbus_err;
                    if (load_q && !dbus.dbus_err) data_d = ld_ext;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pipeline control: stall from launch until the access completes.
    always_comb begin
        stall    = ((state_q == S_IDLE) & go) | (state_q == S_BUSY);
        memwb_we = ~stall;
    end

    assign mem_memory_data = data_q;
    assign mem_fault       = fault_q;
    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_wstrb = wstrb_q;
    assign dbus.dbus_wdata = wdata_q;
endmodule
